// File: rtl/sdram_port_arbiter_if.sv
// Buffer-side and EasySDRAM-side signals of the SDRAM port arbiter.
// master = arbiter side, slave = buffers plus EasySDRAM.
interface sdram_port_arbiter_if;
    logic        wr_req;
    logic [24:0] wr_addr;
    logic [9:0]  wr_data;
    logic        wr_pop;
    logic        rd_req;
    logic [24:0] rd_addr;
    logic        rd_valid;
    logic [9:0]  rd_data;
    logic        ram_busy;
    logic [9:0]  ram_refresh_countdown;
    logic        ram_read_valid;
    logic [15:0] ram_rdata;
    logic        ram_write;
    logic        ram_is_write;
    logic [24:0] ram_address;
    logic [15:0] ram_write_data;
    logic [1:0]  ram_write_mask;
    logic        ram_keep_open;
    logic        grant_wr;
    logic        grant_rd;

    modport master (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
        input  ram_busy, ram_refresh_countdown,
        input  ram_read_valid, ram_rdata,
        output wr_pop, rd_valid, rd_data,
        output ram_write, ram_is_write, ram_address,
        output ram_write_data, ram_write_mask, ram_keep_open,
        output grant_wr, grant_rd
    );

    modport slave (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
        output ram_busy, ram_refresh_countdown,
        output ram_read_valid, ram_rdata,
        input  wr_pop, rd_valid, rd_data,
        input  ram_write, ram_is_write, ram_address,
        input  ram_write_data, ram_write_mask, ram_keep_open,
        input  grant_wr, grant_rd
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Burst arbiter sharing the EasySDRAM command port between camera writes and VGA reads.
// Option macro ARB_READ_PRIORITY_EN: reads win every tie (default: round-robin on ties).
module sdram_port_arbiter #(
    parameter int BURST_LEN     = 8,
    parameter int REFRESH_GUARD = 64
) (
    input  logic                 ram_clk,
    input  logic                 reset,
    sdram_port_arbiter_if.master bus
);
    localparam int BW = $clog2(BURST_LEN);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WR    = 2'd1;
    localparam logic [1:0] S_RD    = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [10:0]   GUARD     = 11'(REFRESH_GUARD);

    logic [1:0]    r_state;
    logic [24:0]   r_base;
    logic [BW-1:0] r_beat;
    logic [BW:0]   r_infl;
    logic          r_last_rd;
    logic          r_rd_valid;
    logic [9:0]    r_rd_data;

    logic w_burst;
    logic w_accept;
    logic w_last;
    logic w_guard_ok;
    logic w_wr_ok;
    logic w_rd_ok;
    logic w_pick_wr;
    logic w_pick_rd;
    logic w_inc;
    logic w_dec;
    logic w_is_wr;
    logic w_unused_rdata;

    assign w_burst    = (r_state == S_WR) || (r_state == S_RD);
    assign w_accept   = w_burst && !bus.ram_busy;
    assign w_last     = w_accept && (r_beat == LAST_BEAT);
    assign w_guard_ok = {1'b0, bus.ram_refresh_countdown} >= GUARD;
    // A write may not start while earlier read data is still outstanding.
    assign w_wr_ok    = bus.wr_req && ((r_infl == '0) || !r_last_rd);
    assign w_rd_ok    = bus.rd_req;
`ifdef ARB_READ_PRIORITY_EN
    assign w_pick_wr  = w_wr_ok && !w_rd_ok;
`else
    assign w_pick_wr  = w_wr_ok && (!w_rd_ok || r_last_rd);
`endif
    assign w_pick_rd  = w_rd_ok && !w_pick_wr;
    assign w_inc      = w_accept && (r_state == S_RD);
    assign w_dec      = bus.ram_read_valid && (r_infl != '0);
    assign w_is_wr    = (r_state == S_WR);
    assign w_unused_rdata = ^bus.ram_rdata[15:10];

    // Burst sequencing: grant in IDLE, one beat per accepted command.
    always_ff @(posedge ram_clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_beat    <= '0;
            r_last_rd <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_guard_ok && w_pick_wr) begin
                        r_state <= S_WR;
                        r_base  <= bus.wr_addr;
                        r_beat  <= '0;
                    end else if (w_guard_ok && w_pick_rd) begin
                        r_state <= S_RD;
                        r_base  <= bus.rd_addr;
                        r_beat  <= '0;
                    end
                end
                S_WR, S_RD: begin
                    if (w_accept) begin
                        r_beat <= r_beat + BW'(1);
                    end
                    if (w_last) begin
                        r_state   <= (r_state == S_WR) ? S_IDLE : S_DRAIN;
                        r_last_rd <= (r_state == S_RD);
                    end
                end
                default: begin
                    if (r_infl == '0) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Outstanding read beats; a stray valid at zero is ignored.
    always_ff @(posedge ram_clk) begin
        if (reset) begin
            r_infl <= '0;
        end else if (w_inc && !w_dec) begin
            r_infl <= r_infl + (BW+1)'(1);
        end else if (w_dec && !w_inc) begin
            r_infl <= r_infl - (BW+1)'(1);
        end
    end

    // Read return path, one register stage in every state.
    always_ff @(posedge ram_clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= bus.ram_read_valid;
            r_rd_data  <= bus.ram_rdata[9:0];
        end
    end

    assign bus.ram_write      = w_accept;
    assign bus.ram_is_write   = w_is_wr;
    assign bus.ram_address    = w_burst ? (r_base + 25'(r_beat)) : '0;
    assign bus.ram_write_data = w_is_wr ? {6'b0, bus.wr_data} : '0;
    assign bus.ram_write_mask = w_is_wr ? 2'b11 : 2'b00;
    assign bus.ram_keep_open  = w_burst && (r_beat != LAST_BEAT);
    assign bus.wr_pop         = w_accept && w_is_wr;
    assign bus.grant_wr       = w_is_wr;
    assign bus.grant_rd       = (r_state == S_RD) || (r_state == S_DRAIN);
    assign bus.rd_valid       = r_rd_valid;
    assign bus.rd_data        = r_rd_data;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: burst-level model predicts
// commands, grants and read returns; a negedge monitor compares.
module tb_sdram_port_arbiter;
    localparam int BL    = 8;
    localparam int GUARD = 64;

    logic clk = 1'b0;
    logic reset;
    sdram_port_arbiter_if bus();

    sdram_port_arbiter #(.BURST_LEN(BL), .REFRESH_GUARD(GUARD)) dut (
        .ram_clk (clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          w;
        logic [24:0] a;
        bit          k;
        logic [15:0] d;
    } cmd_t;
    typedef struct {
        int         due;
        logic [9:0] d;
    } rdx_t;

    cmd_t       cmd_q[$];
    rdx_t       rd_q[$];
    logic [1:0] gnt_q[$];
    int         pend_q[$];

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    int lat_lo = 1;
    int lat_hi = 6;
    bit stray_en = 0;
    logic [24:0] g_wa = '0;
    logic [24:0] g_ra = '0;

    // Burst-level model: who owns the port, beats still owed,
    // next address, outstanding reads, who went last.
    int          m_owner   = 0;
    int          m_left    = 0;
    bit          m_drain   = 0;
    logic [24:0] m_addr    = '0;
    int          m_infl    = 0;
    bit          m_last_rd = 1;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", n, cyc, act, exp);
        end
    endtask

    task automatic model_update();
        int old_infl;
        bit acc;
        int winner;
        int due;
        if (reset) begin
            m_owner = 0; m_left = 0; m_drain = 0;
            m_infl = 0; m_last_rd = 1;
            pend_q.delete();
            return;
        end
        old_infl = m_infl;
        acc = (m_owner != 0) && !m_drain && !bus.ram_busy;
        if (acc && m_owner == 2) m_infl++;
        if (bus.ram_read_valid && old_infl > 0) m_infl--;
        if (m_owner == 0) begin
            winner = 0;
            if (bus.ram_refresh_countdown >= GUARD) begin
                bit wok;
                wok = bus.wr_req && (old_infl == 0 || !m_last_rd);
                if (wok && bus.rd_req) begin
`ifdef ARB_READ_PRIORITY_EN
                    winner = 2;
`else
                    winner = m_last_rd ? 1 : 2;
`endif
                end else if (wok) begin
                    winner = 1;
                end else if (bus.rd_req) begin
                    winner = 2;
                end
            end
            if (winner != 0) begin
                m_owner = winner;
                m_left  = BL;
                m_addr  = (winner == 1) ? bus.wr_addr : bus.rd_addr;
            end
        end else if (m_drain) begin
            if (old_infl == 0) begin
                m_owner = 0;
                m_drain = 0;
            end
        end else if (acc) begin
            if (m_owner == 2) begin
                due = cyc + int'($urandom_range(lat_hi, lat_lo));
                if (pend_q.size() > 0 && due <= pend_q[$]) due = pend_q[$] + 1;
                pend_q.push_back(due);
            end
            m_addr = m_addr + 25'd1;
            m_left--;
            if (m_left == 0) begin
                if (m_owner == 1) begin
                    m_owner = 0;
                    m_last_rd = 0;
                end else begin
                    m_drain = 1;
                    m_last_rd = 1;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit w, input bit rq,
                        input bit b, input int cd);
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        reset = r;
        bus.wr_req = w;
        bus.rd_req = rq;
        bus.ram_busy = b;
        bus.ram_refresh_countdown = 10'(cd);
        bus.wr_addr = g_wa;
        bus.rd_addr = g_ra;
        bus.wr_data = 10'($urandom);
        bus.ram_rdata = 16'($urandom);
        bus.ram_read_valid = 1'b0;
        if (!r && pend_q.size() > 0 && pend_q[0] == cyc) begin
            void'(pend_q.pop_front());
            bus.ram_read_valid = 1'b1;
        end else if (!r && stray_en && pend_q.size() == 0 && m_infl == 0
                     && $urandom_range(7, 0) == 0) begin
            bus.ram_read_valid = 1'b1;
        end
        if (bus.ram_read_valid)
            rd_q.push_back('{cyc + 1, bus.ram_rdata[9:0]});
        gnt_q.push_back({m_owner == 1, m_owner == 2});
        if (m_owner != 0 && !m_drain && !b)
            cmd_q.push_back('{m_owner == 1, m_addr, m_left != 1,
                              (m_owner == 1) ? {6'b0, bus.wr_data} : 16'h0});
    endtask

    // Monitor: pop expectations whenever the DUT shows an output.
    always @(negedge clk) begin
        cmd_t c;
        rdx_t x;
        logic [1:0] g;
        bit have;
        if (gnt_q.size() > 0) begin
            g = gnt_q.pop_front();
            chk("grant", 32'({bus.grant_wr, bus.grant_rd}), 32'(g));
        end
        have = cmd_q.size() > 0;
        chk("cmd_strobe", 32'(bus.ram_write), 32'(have));
        if (have) begin
            c = cmd_q.pop_front();
            if (bus.ram_write) begin
                chk("cmd_is_write", 32'(bus.ram_is_write), 32'(c.w));
                chk("cmd_addr", 32'(bus.ram_address), 32'(c.a));
                chk("cmd_keep_open", 32'(bus.ram_keep_open), 32'(c.k));
                if (c.w) begin
                    chk("cmd_wdata", 32'(bus.ram_write_data), 32'(c.d));
                    chk("cmd_mask", 32'(bus.ram_write_mask), 32'h3);
                end
            end
        end
        chk("wr_pop", 32'(bus.wr_pop), 32'(have && c.w));
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            x = rd_q.pop_front();
            chk("rd_valid", 32'(bus.rd_valid), 32'd1);
            chk("rd_data", 32'(bus.rd_data), 32'(x.d));
        end else begin
            chk("rd_valid_idle", 32'(bus.rd_valid), 32'd0);
        end
    end

    initial begin
        reset = 1'b1;
        bus.wr_req = 0; bus.rd_req = 0; bus.ram_busy = 0;
        bus.ram_refresh_countdown = 10'd1000;
        bus.wr_addr = '0; bus.rd_addr = '0; bus.wr_data = '0;
        bus.ram_read_valid = 0; bus.ram_rdata = '0;
        repeat (3) step(1, 0, 0, 0, 1000);
        // write-only burst at 0x100
        g_wa = 25'h100;
        step(0, 1, 0, 0, 1000);
        repeat (14) step(0, 0, 0, 0, 1000);
        // read burst at 0x20, data 3 cycles late
        lat_lo = 3; lat_hi = 3;
        g_ra = 25'h20;
        step(0, 0, 1, 0, 1000);
        repeat (22) step(0, 0, 0, 0, 1000);
        // both requesting from reset: alternate
        repeat (2) step(1, 0, 0, 0, 1000);
        lat_lo = 1; lat_hi = 6;
        g_wa = 25'h200; g_ra = 25'h300;
        repeat (70) step(0, 1, 1, 0, 1000);
        repeat (20) step(0, 0, 0, 0, 1000);
        // refresh guard: blocked start, then burst under low countdown
        repeat (6) step(0, 1, 1, 0, 63);
        step(0, 1, 0, 0, 64);
        repeat (12) step(0, 0, 0, 0, 40);
        repeat (3) step(0, 0, 0, 0, 1000);
        // busy toggling with address wrap
        g_wa = 25'h1FFFFFE;
        step(0, 1, 0, 0, 1000);
        for (int i = 0; i < 22; i++) step(0, 0, 0, i % 2 == 0, 1000);
        // reset mid write burst
        g_wa = 25'h40;
        step(0, 1, 0, 0, 1000);
        repeat (4) step(0, 0, 0, 0, 1000);
        step(1, 0, 0, 0, 1000);
        repeat (3) step(0, 0, 0, 0, 1000);
        // reset mid read burst, then a write must still start
        g_ra = 25'h80; lat_lo = 4; lat_hi = 4;
        step(0, 0, 1, 0, 1000);
        repeat (4) step(0, 0, 0, 0, 1000);
        step(1, 0, 0, 0, 1000);
        step(0, 1, 0, 0, 1000);
        repeat (12) step(0, 0, 0, 0, 1000);
        // randomized traffic
        lat_lo = 1; lat_hi = 6; stray_en = 1;
        begin
            bit w, r;
            w = 0; r = 0;
            for (int i = 0; i < 2500; i++) begin
                int cd;
                if ($urandom_range(7, 0) == 0) w = ~w;
                if ($urandom_range(7, 0) == 0) r = ~r;
                g_wa = ($urandom_range(7, 0) == 0) ? 25'h1FFFFF8 + 25'($urandom_range(7, 0))
                                                  : 25'($urandom);
                g_ra = 25'($urandom);
                cd = ($urandom_range(9, 0) == 0) ? int'($urandom_range(100, 0)) : 1000;
                step($urandom_range(399, 0) == 0, w, r,
                     $urandom_range(9, 0) < 3, cd);
            end
        end
        stray_en = 0;
        repeat (30) step(0, 0, 0, 0, 1000);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
